// File: rtl/btn_cond4.sv
// Four-channel push-button conditioner: 2-flop synchroniser, counter debounce,
// and single-cycle press / release / auto-repeat pulses used as clock enables.
module btn_cond4 #(
  parameter int N_BTN     = 4,
  parameter int DB_CYCLES = 1000000,
  parameter int RPT_DELAY = 50000000,
  parameter int RPT_RATE  = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             rpt_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int DCW     = $clog2(DB_CYCLES) + 1;
  localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int HCW     = $clog2(RPT_MAX) + 1;

  localparam logic [DCW-1:0] DC_LAST  = DCW'(DB_CYCLES - 1);
  localparam logic [HCW-1:0] HC_DELAY = HCW'(RPT_DELAY - 1);
  localparam logic [HCW-1:0] HC_RATE  = HCW'(RPT_RATE - 1);

  logic [N_BTN-1:0]           sync1_q, sync1_d;
  logic [N_BTN-1:0]           sync2_q, sync2_d;
  logic [N_BTN-1:0]           level_q, level_d;
  logic [N_BTN-1:0][DCW-1:0]  dc_q, dc_d;
  logic [N_BTN-1:0][HCW-1:0]  hc_q, hc_d;
  logic [N_BTN-1:0]           phase_q, phase_d;
  logic [N_BTN-1:0]           press_q, press_d;
  logic [N_BTN-1:0]           release_q, release_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    level_d   = level_q;
    dc_d      = dc_q;
    hc_d      = hc_q;
    phase_d   = phase_q;
    press_d   = '0;
    release_d = '0;

    for (int i = 0; i < N_BTN; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        dc_d[i] = '0;
      end else if (dc_q[i] < DC_LAST) begin
        dc_d[i] = dc_q[i] + 1'b1;
      end else begin
        level_d[i]   = sync2_q[i];
        dc_d[i]      = '0;
        press_d[i]   = sync2_q[i];
        release_d[i] = ~sync2_q[i];
      end

      // An accepted edge owns this cycle; the repeat timer restarts and cannot pulse.
      if (press_d[i] || release_d[i]) begin
        hc_d[i]    = '0;
        phase_d[i] = 1'b0;
      end else if (level_q[i] && rpt_en) begin
        if (hc_q[i] >= (phase_q[i] ? HC_RATE : HC_DELAY)) begin
          press_d[i] = 1'b1;
          hc_d[i]    = '0;
          phase_d[i] = 1'b1;
        end else begin
          hc_d[i] = hc_q[i] + 1'b1;
        end
      end else begin
        hc_d[i]    = '0;
        phase_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      dc_q      <= '0;
      hc_q      <= '0;
      phase_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      dc_q      <= dc_d;
      hc_q      <= hc_d;
      phase_q   <= phase_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule
